// File: rtl/aes_pkg.sv
// Shared AES definitions for the decipher key store: key-length codes, round
// limits, key-generator state encoding and the rcon/word helper functions.
package aes_pkg;

  localparam logic       AES_128_BIT_KEY = 1'h0;
  localparam logic       AES_256_BIT_KEY = 1'h1;
  localparam logic [3:0] AES128_ROUNDS   = 4'ha;
  localparam logic [3:0] AES256_ROUNDS   = 4'he;
  localparam int         NUM_KEYS        = 15;
  localparam logic [7:0] RCON_INIT       = 8'h01;

  typedef enum logic {
    CTRL_IDLE = 1'b0,
    CTRL_GEN  = 1'b1
  } ctrl_state_e;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (8'h1b & {8{r[7]}});
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_dec_key_mem_if.sv
// Caller-facing bundle of the round-key store. With AES_KEY_MEM_ZEROIZE_EN
// defined the bundle also carries the zeroize request.
interface aes_dec_key_mem_if;

`ifdef AES_KEY_MEM_ZEROIZE_EN
  logic         zeroize;
`endif
  logic         init;
  logic         keylen;
  logic [255:0] key;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         ready;

  modport master (
`ifdef AES_KEY_MEM_ZEROIZE_EN
    output zeroize,
`endif
    output init, keylen, key, round,
    input  round_key, ready
  );

  modport slave (
`ifdef AES_KEY_MEM_ZEROIZE_EN
    input  zeroize,
`endif
    input  init, keylen, key, round,
    output round_key, ready
  );

endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box applied to all four bytes of a 32-bit word (SubWord).
// Purely combinational table lookup.
module aes_sbox (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  // Byte 0x00 sits in the top byte, byte 0xff in the bottom byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    logic [10:0] pos;
    pos = {~b, 3'b000};
    return SBOX[pos +: 8];
  endfunction

  assign word_o = {sub_byte(word_i[31:24]), sub_byte(word_i[23:16]),
                   sub_byte(word_i[15:8]),  sub_byte(word_i[7:0])};

endmodule

// File: rtl/aes_dec_key_mem.sv
// Round-key generator and 15-entry store for the AES decipher datapath; one
// key per cycle. Define AES_KEY_MEM_ZEROIZE_EN to add the zeroize request.
module aes_dec_key_mem
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  aes_dec_key_mem_if.slave bus
);

  ctrl_state_e  state_q, state_d;
  logic [3:0]   ctr_q, ctr_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         keylen_q, keylen_d;
  logic [127:0] prev_q, prev_d;
  logic [127:0] prev2_q, prev2_d;
  logic [127:0] mem_q [NUM_KEYS];

  logic         we_a, we_b;
  logic [3:0]   waddr_a;
  logic [127:0] wdata_a;
`ifdef AES_KEY_MEM_ZEROIZE_EN
  logic         clear;
`endif

  logic         is_256, use_rcon;
  logic [3:0]   last_round;
  logic [31:0]  sbox_in, sbox_out, t_word;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] base_key, next_key;

  // Odd AES-256 steps skip RotWord and rcon; every AES-128 step uses both.
  assign is_256     = (keylen_q == AES_256_BIT_KEY);
  assign use_rcon   = !is_256 || !ctr_q[0];
  assign last_round = is_256 ? AES256_ROUNDS : AES128_ROUNDS;
  assign sbox_in    = use_rcon ? rot_word(prev_q[31:0]) : prev_q[31:0];

  aes_sbox u_sbox (
    .word_i (sbox_in),
    .word_o (sbox_out)
  );

  assign t_word   = sbox_out ^ (use_rcon ? {rcon_q, 24'h0} : 32'h0);
  assign base_key = is_256 ? prev2_q : prev_q;
  assign n0       = base_key[127:96] ^ t_word;
  assign n1       = base_key[95:64]  ^ n0;
  assign n2       = base_key[63:32]  ^ n1;
  assign n3       = base_key[31:0]   ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // NOTE: every signal gets its hold value before the case, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    rcon_d   = rcon_q;
    keylen_d = keylen_q;
    prev_d   = prev_q;
    prev2_d  = prev2_q;
    we_a     = 1'b0;
    we_b     = 1'b0;
    waddr_a  = ctr_q;
    wdata_a  = next_key;
`ifdef AES_KEY_MEM_ZEROIZE_EN
    clear    = 1'b0;
`endif

    unique case (state_q)
      CTRL_IDLE: begin
        if (bus.init) begin
          we_a     = 1'b1;
          waddr_a  = 4'd0;
          wdata_a  = bus.key[255:128];
          keylen_d = bus.keylen;
          rcon_d   = RCON_INIT;
          state_d  = CTRL_GEN;
          if (bus.keylen == AES_256_BIT_KEY) begin
            we_b    = 1'b1;
            prev2_d = bus.key[255:128];
            prev_d  = bus.key[127:0];
            ctr_d   = 4'd2;
          end else begin
            prev_d  = bus.key[255:128];
            ctr_d   = 4'd1;
          end
        end
      end
      CTRL_GEN: begin
        we_a    = 1'b1;
        prev2_d = prev_q;
        prev_d  = next_key;
        ctr_d   = ctr_q + 4'd1;
        if (use_rcon) rcon_d = xtime(rcon_q);
        if (ctr_q == last_round) begin
          state_d = CTRL_IDLE;
          ctr_d   = 4'd0;
        end
      end
      default: state_d = CTRL_IDLE;
    endcase

`ifdef AES_KEY_MEM_ZEROIZE_EN
    // Zeroize overrides everything, including an init in the same cycle.
    if (bus.zeroize) begin
      state_d = CTRL_IDLE;
      ctr_d   = 4'd0;
      rcon_d  = RCON_INIT;
      prev_d  = '0;
      prev2_d = '0;
      we_a    = 1'b0;
      we_b    = 1'b0;
      clear   = 1'b1;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= CTRL_IDLE;
      ctr_q    <= 4'd0;
      rcon_q   <= RCON_INIT;
      keylen_q <= AES_128_BIT_KEY;
      prev_q   <= '0;
      prev2_q  <= '0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      rcon_q   <= rcon_d;
      keylen_q <= keylen_d;
      prev_q   <= prev_d;
      prev2_q  <= prev2_d;
    end
  end

  // NOTE: the store is reset on purpose: key material must not survive a reset,
  // which rules out a RAM macro without a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_KEYS; i++) mem_q[i] <= '0;
    end else begin
`ifdef AES_KEY_MEM_ZEROIZE_EN
      if (clear) begin
        for (int i = 0; i < NUM_KEYS; i++) mem_q[i] <= '0;
      end else
`endif
      begin
        if (we_a) mem_q[waddr_a] <= wdata_a;
        if (we_b) mem_q[1]       <= bus.key[127:0];
      end
    end
  end

  assign bus.round_key = (bus.round <= AES256_ROUNDS) ? mem_q[bus.round] : '0;
  assign bus.ready     = (state_q == CTRL_IDLE);

endmodule

// File: tb/tb_aes_dec_key_mem.sv
// Self-checking bench for aes_dec_key_mem: FIPS-197 vectors, random keys
// against a word-level key-expansion model, and multi-cycle corner cases.
module tb_aes_dec_key_mem;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  aes_dec_key_mem_if bus ();

  aes_dec_key_mem dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_keys [15];

  localparam logic [255:0] KEY_A1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  typedef struct {
    logic         kl;
    logic [255:0] key;
    int           busy;
    logic [3:0]   r0;
    logic [127:0] e0;
    logic [3:0]   r1;
    logic [127:0] e1;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model: FIPS-197 word expansion ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    logic [7:0] s;
    repeat (254) inv = gf_mul(inv, x);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] sub_word_ref(input logic [31:0] w);
    return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
  endfunction

  task automatic build_model(input logic kl, input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] temp;
    int nk, total, rc;
    nk    = kl ? 8 : 4;
    total = kl ? 60 : 44;
    rc    = 1;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < total; i++) begin
      temp = w[i-1];
      if (i % nk == 0) begin
        temp = sub_word_ref({temp[23:0], temp[31:24]}) ^ {rc[7:0], 24'h0};
        rc = rc * 2;
        if (rc > 255) rc = rc ^ 'h11b;
      end else if (nk == 8 && i % nk == 4) begin
        temp = sub_word_ref(temp);
      end
      w[i] = w[i-nk] ^ temp;
    end
    for (int r = 0; r < 15; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [255:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Call at a negedge; returns at the next negedge with init dropped and the
  // key/keylen inputs scrambled so late changes would be visible.
  task automatic start(input logic kl, input logic [255:0] k);
    bus.init   = 1'b1;
    bus.keylen = kl;
    bus.key    = k;
    @(negedge clk);
    bus.init   = 1'b0;
    bus.keylen = ~kl;
    bus.key    = ~k;
  endtask

  task automatic wait_ready(output int busy);
    busy = 0;
    while (!bus.ready && busy < 50) begin
      busy++;
      @(negedge clk);
    end
  endtask

  task automatic read_key(input int r, output logic [127:0] v);
    bus.round = 4'(r);
    #1;
    v = bus.round_key;
  endtask

  task automatic check_all(input string name, input int last);
    logic [127:0] v;
    for (int r = 0; r <= last; r++) begin
      read_key(r, v);
      check($sformatf("%s rk%0d", name, r), v, exp_keys[r]);
    end
    @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    logic [127:0] v;
    for (int r = 0; r < 15; r++) begin
      read_key(r, v);
      check($sformatf("%s rk%0d", name, r), v, 128'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [2];
    int busy;
    logic [127:0] v;
    logic [255:0] k;

    vecs[0] = '{kl: 1'b0, key: KEY_A1, busy: 10,
                r0: 4'd0,  e0: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                r1: 4'd10, e1: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{kl: 1'b1, key: KEY_A3, busy: 13,
                r0: 4'd1,  e0: 128'h1f352c073b6108d72d9810a30914dff4,
                r1: 4'd14, e1: 128'hfe4890d1e6188d0b046df344706c631e};

    reset_n    = 1'b0;
    bus.init   = 1'b0;
    bus.keylen = 1'b0;
    bus.key    = '0;
    bus.round  = '0;
`ifdef AES_KEY_MEM_ZEROIZE_EN
    bus.zeroize = 1'b0;
`endif

    // Reset state
    #12;
    check("reset ready", 128'(bus.ready), 128'h1);
    check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // FIPS-197 vectors plus full-store comparison against the model
    for (int i = 0; i < 2; i++) begin
      start(vecs[i].kl, vecs[i].key);
      wait_ready(busy);
      check($sformatf("vec%0d busy", i), 128'(busy), 128'(vecs[i].busy));
      read_key(int'(vecs[i].r0), v);
      check($sformatf("vec%0d fips rk%0d", i, vecs[i].r0), v, vecs[i].e0);
      read_key(int'(vecs[i].r1), v);
      check($sformatf("vec%0d fips rk%0d", i, vecs[i].r1), v, vecs[i].e1);
      build_model(vecs[i].kl, vecs[i].key);
      check_all($sformatf("vec%0d", i), vecs[i].kl ? 14 : 10);
    end

    // init while busy is ignored
    start(AES_128_BIT_KEY, KEY_A1);
    repeat (3) @(negedge clk);
    bus.init   = 1'b1;
    bus.keylen = AES_256_BIT_KEY;
    bus.key    = rand_key();
    @(negedge clk);
    bus.init   = 1'b0;
    wait_ready(busy);
    check("busy-init remaining", 128'(busy), 128'd6);
    build_model(AES_128_BIT_KEY, KEY_A1);
    check_all("busy-init", 10);

    // Back-to-back: init in the first ready cycle is accepted
    k = rand_key();
    start(AES_256_BIT_KEY, k);
    wait_ready(busy);
    check("b2b first busy", 128'(busy), 128'd13);
    k = rand_key();
    start(AES_128_BIT_KEY, k);
    check("b2b ready low", 128'(bus.ready), 128'h0);
    wait_ready(busy);
    check("b2b second busy", 128'(busy), 128'd10);
    build_model(AES_128_BIT_KEY, k);
    check_all("b2b", 10);

    // Reset in the middle of an expansion clears everything
    start(AES_256_BIT_KEY, KEY_A3);
    wait_ready(busy);
    @(negedge clk);
    start(AES_256_BIT_KEY, rand_key());
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset ready", 128'(bus.ready), 128'h1);
    check_zero("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post-reset ready", 128'(bus.ready), 128'h1);

    // Random keys against the model
    for (int n = 0; n < 6; n++) begin
      logic kl;
      kl = n[0];
      k  = rand_key();
      start(kl, k);
      wait_ready(busy);
      check($sformatf("rand%0d busy", n), 128'(busy), kl ? 128'd13 : 128'd10);
      build_model(kl, k);
      check_all($sformatf("rand%0d", n), kl ? 14 : 10);
    end

`ifdef AES_KEY_MEM_ZEROIZE_EN
    // Zeroize with init high aborts the expansion and drops the init
    start(AES_256_BIT_KEY, KEY_A3);
    repeat (4) @(negedge clk);
    bus.zeroize = 1'b1;
    bus.init    = 1'b1;
    bus.keylen  = AES_256_BIT_KEY;
    bus.key     = KEY_A3;
    @(negedge clk);
    bus.zeroize = 1'b0;
    bus.init    = 1'b0;
    check("zeroize ready", 128'(bus.ready), 128'h1);
    check_zero("zeroize");
    @(negedge clk);
    check("zeroize init dropped", 128'(bus.ready), 128'h1);
    start(AES_128_BIT_KEY, KEY_A1);
    wait_ready(busy);
    check("post-zeroize busy", 128'(busy), 128'd10);
    build_model(AES_128_BIT_KEY, KEY_A1);
    check_all("post-zeroize", 10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
